// File: rtl/random_delay_gen_if.sv
// Request/status bundle between the control core (master) and random_delay_gen (slave).
interface random_delay_gen_if;
    logic        random_count;
    logic [12:0] rtime;
    logic        time_out;
    logic        busy;
    logic [12:0] elapsed;

    modport master (output random_count, input rtime, time_out, busy, elapsed);
    modport slave  (input random_count, output rtime, time_out, busy, elapsed);
endinterface

// File: rtl/random_delay_gen.sv
// Pseudo-random millisecond delay generator: a free-running 16-bit LFSR picks the delay at run start.
// Build option: define RDG_FIXED_DELAY_EN to latch a constant 3000 ms delay instead of the LFSR value.
module random_delay_gen #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned MIN_MS    = 1000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             clr,
    random_delay_gen_if.slave bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    if (MIN_MS + 4095 > 8191) begin : g_min_ms_check
        $error("random_delay_gen: MIN_MS + 4095 exceeds the 13-bit rtime range");
    end
    if (TICK_DIV < 2 || TICK_DIV > (1 << 20)) begin : g_tick_div_check
        $error("random_delay_gen: TICK_DIV must lie in 2..2^20");
    end

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

    state_e        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [12:0]   rtime_q, rtime_d;
    logic [12:0]   elapsed_q, elapsed_d;
    logic          time_out_q, time_out_d;
    logic          busy_q, busy_d;

    logic          tick;
    logic          last_tick;
    logic [12:0]   new_rtime;

    // Fibonacci LFSR, taps 16,14,13,11 in right-shift form (tap t reads bit 16-t).
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    assign tick      = (state_q == COUNT) && (presc_q == PRESC_LAST);
    assign last_tick = tick && ((elapsed_q + 13'd1) == rtime_q);

`ifdef RDG_FIXED_DELAY_EN
    assign new_rtime = 13'd3000;
`else
    assign new_rtime = 13'(MIN_MS) + {1'b0, lfsr_q[11:0]};
`endif

    // State register plus all registered outputs.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            presc_q    <= '0;
            rtime_q    <= '0;
            elapsed_q  <= '0;
            time_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            presc_q    <= presc_d;
            rtime_q    <= rtime_d;
            elapsed_q  <= elapsed_d;
            time_out_q <= time_out_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; a low request aborts from any state and beats the final tick.
    always_comb begin
        // NOTE: assign a default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.random_count) state_d = COUNT;
            COUNT:   if (!bus.random_count) state_d = IDLE;
                     else if (last_tick)    state_d = DONE;
            DONE:    if (!bus.random_count) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        rtime_d    = rtime_q;
        elapsed_d  = elapsed_q;
        presc_d    = presc_q;
        time_out_d = time_out_q;
        busy_d     = (state_d == COUNT);
        if (!bus.random_count) begin
            elapsed_d  = '0;
            presc_d    = '0;
            time_out_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rtime_d    = new_rtime;
                    elapsed_d  = '0;
                    presc_d    = '0;
                    time_out_d = 1'b0;
                end
                COUNT: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick)      elapsed_d  = elapsed_q + 13'd1;
                    if (last_tick) time_out_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rtime    = rtime_q;
    assign bus.elapsed  = elapsed_q;
    assign bus.time_out = time_out_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_random_delay_gen.sv
// Self-checking bench for random_delay_gen (TICK_DIV=4, MIN_MS=10) against a behavioural LFSR/timing model.
module tb_random_delay_gen;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned MIN_MS    = 10;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          LIMIT     = 8192 * TICK_DIV + 16;

    logic clk;
    logic clr;
    random_delay_gen_if bus ();

    random_delay_gen #(
        .TICK_DIV (TICK_DIV),
        .MIN_MS   (MIN_MS),
        .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural LFSR: taps listed as polynomial exponents, tap t reads bit 16-t, new bit enters at the top.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int   taps [4];
        logic b;
        taps = '{16, 14, 13, 11};
        b = 1'b0;
        foreach (taps[i]) b ^= s[16 - taps[i]];
        return {b, s[15:1]};
    endfunction

    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_lfsr <= LFSR_SEED;
            m_prev <= LFSR_SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    function automatic logic [12:0] expected_rtime(input logic [15:0] l);
`ifdef RDG_FIXED_DELAY_EN
        return 13'd3000;
`else
        return 13'(MIN_MS + int'(l[11:0]));
`endif
    endfunction

    // Called at a negedge; raises the request after gap cycles and checks the run-start state.
    task automatic start_run(input int gap, output logic [12:0] rt);
        repeat (gap) @(negedge clk);
        bus.random_count = 1'b1;
        @(negedge clk);
        rt = expected_rtime(m_prev);
        check("start_rtime", 32'(bus.rtime), 32'(rt));
        check("start_busy", 32'(bus.busy), 1);
        check("start_elapsed", 32'(bus.elapsed), 0);
        check("start_time_out", 32'(bus.time_out), 0);
    endtask

    // Counts cycles from run start until time_out, tracking elapsed against floor(n/TICK_DIV).
    task automatic wait_done(input logic [12:0] rt);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (n < LIMIT) begin
            @(negedge clk);
            n++;
            if (bus.time_out) break;
            if (bus.elapsed != 13'(n / TICK_DIV) || !bus.busy) bad++;
        end
        check("elapsed_track", 32'(bad), 0);
        check("done_latency", 32'(n), 32'(int'(rt) * TICK_DIV));
        check("done_elapsed", 32'(bus.elapsed), 32'(rt));
        check("done_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        logic [12:0] rt_a, rt_b, rt_c, rt_d;
        int bad;
        int n;

        clr = 1'b1;
        bus.random_count = 1'b0;
        #12;
        check("rst_rtime", 32'(bus.rtime), 0);
        check("rst_elapsed", 32'(bus.elapsed), 0);
        check("rst_time_out", 32'(bus.time_out), 0);
        check("rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        clr = 1'b0;

        // Run A: full delay, then hold the request high in DONE.
        start_run(5, rt_a);
`ifndef RDG_FIXED_DELAY_EN
        check("a_range", 32'(rt_a >= 13'(MIN_MS) && rt_a <= 13'(MIN_MS + 4095)), 1);
`endif
        wait_done(rt_a);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.time_out || bus.elapsed != rt_a || bus.busy) bad++;
        end
        check("done_hold", 32'(bad), 0);
        bus.random_count = 1'b0;
        @(negedge clk);
        check("idle_time_out", 32'(bus.time_out), 0);
        check("idle_elapsed", 32'(bus.elapsed), 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_rtime_kept", 32'(bus.rtime), 32'(rt_a));

        // Run B: abort halfway through the count.
        start_run(9, rt_b);
`ifndef RDG_FIXED_DELAY_EN
        check("b_range", 32'(rt_b >= 13'(MIN_MS) && rt_b <= 13'(MIN_MS + 4095)), 1);
        check("b_differs", 32'(rt_b != rt_a), 1);
`endif
        n = 0;
        while (bus.elapsed < rt_b / 2 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("b_half_reached", 32'(n < LIMIT), 1);
        bus.random_count = 1'b0;
        @(negedge clk);
        check("abort_time_out", 32'(bus.time_out), 0);
        check("abort_elapsed", 32'(bus.elapsed), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_rtime_kept", 32'(bus.rtime), 32'(rt_b));

        // Run C: drop the request on the edge that carries the final tick.
        start_run($urandom_range(1, 20), rt_c);
        repeat (int'(rt_c) * TICK_DIV - 1) @(negedge clk);
        check("c_pre_final_elapsed", 32'(bus.elapsed), 32'(rt_c - 13'd1));
        bus.random_count = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.time_out || bus.busy || bus.elapsed != 13'd0) bad++;
        end
        check("final_tick_abort", 32'(bad), 0);

        // Run D: asynchronous clear mid-count, then a fresh run from the reseeded LFSR.
        start_run($urandom_range(1, 20), rt_d);
        repeat (30) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_rtime", 32'(bus.rtime), 0);
        check("clr_elapsed", 32'(bus.elapsed), 0);
        check("clr_time_out", 32'(bus.time_out), 0);
        check("clr_busy", 32'(bus.busy), 0);
        bus.random_count = 1'b0;
        @(negedge clk);
        #3 clr = 1'b0;
        @(negedge clk);
        start_run($urandom_range(0, 12), rt_d);
        wait_done(rt_d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/random_delay_gen.md
RANDOM_DELAY_GEN -- requirements
Module: random_delay_gen

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per 1 ms tick (legal 2..2^20).
REQ-002 Parameter MIN_MS, default 1000, minimum delay in ms.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-004 clk  input  1  single system clock, rising-edge.
REQ-005 clr  input  1  reset; asynchronous, active-high.
REQ-006 random_count  input  1  level request from control core; high = run delay, low = abort/idle.
REQ-007 rtime  output  13  delay in ms latched for the current run.
REQ-008 time_out  output  1  high once the latched delay has elapsed.
REQ-009 busy  output  1  high while counting (state COUNT).
REQ-010 elapsed  output  13  ms elapsed in the current run.

Function
REQ-011 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL shift every clk cycle regardless of state.
REQ-012 FSM states SHALL be IDLE, COUNT, DONE.
REQ-013 IDLE with random_count=1 at an edge: latch rtime = MIN_MS + lfsr[11:0]; clear prescaler and elapsed; go to COUNT.
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 in COUNT only; tick on terminal count; then wrap to 0.
REQ-015 Each tick in COUNT SHALL increment elapsed by 1.
REQ-016 On the tick that makes elapsed equal rtime: go to DONE, time_out=1 at that same edge.
REQ-017 DONE SHALL hold time_out=1, elapsed=rtime; prescaler stopped.
REQ-018 random_count=0 in any state: next edge -> IDLE, time_out=0, elapsed=0, prescaler=0; rtime holds last value.
REQ-019 random_count=0 on the same edge as the final tick: abort wins; time_out stays 0.
REQ-020 A new run SHALL require random_count to return to IDLE first (low for >=1 cycle); staying high in DONE does not restart.
REQ-021 MIN_MS + 4095 SHALL be <= 8191; a violating value is a configuration error (elaboration check).
REQ-022 Total delay from COUNT entry to time_out = rtime*TICK_DIV cycles exactly.
REQ-023 busy SHALL equal (state==COUNT); all outputs registered.

Reset
REQ-024 clr=1 SHALL asynchronously force state=IDLE, lfsr=LFSR_SEED, rtime=0, elapsed=0, prescaler=0, time_out=0, busy=0.
REQ-025 clr asserted mid-COUNT SHALL abort the run; after release, the FSM is in IDLE and waits for random_count.
REQ-026 First LFSR shift SHALL occur on the first rising edge after clr deasserts.

Configuration
REQ-027 Macro RDG_FIXED_DELAY_EN defined: rtime SHALL latch constant 13'd3000 at every run start (LFSR still runs, unused).
REQ-028 Macro RDG_FIXED_DELAY_EN undefined: rtime SHALL latch MIN_MS + lfsr[11:0] per REQ-013.

Verification (TICK_DIV=4, MIN_MS=10 unless noted)
REQ-029 Reset, then random_count=1 at edge 0 -> busy=1 from edge 0, time_out rises exactly rtime*4 cycles later, elapsed==rtime.
REQ-030 RDG_FIXED_DELAY_EN defined, random_count=1 -> rtime=3000, time_out after 12000 cycles.
REQ-031 random_count dropped to 0 halfway through COUNT -> next edge time_out=0, elapsed=0, busy=0; rtime unchanged.
REQ-032 random_count dropped on the final-tick edge -> time_out never asserts; state IDLE.
REQ-033 clr pulsed mid-COUNT (asynchronous to clk) -> all outputs 0 immediately; lfsr=16'hACE1; new run after release.
REQ-034 Two runs with different idle gaps (5 vs 9 cycles) -> rtime values differ, both in 10..4105.
